// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with input skew,
// K sequencing, pipeline flush, tiled-K carry-over and row-wise drain.
module systolic_array_os #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int K_MAX  = 256,
   localparam int KW    = $clog2(K_MAX + 1),
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   input  logic                    acc_keep,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ROWS*DATA_W-1:0]  x_in,
   input  logic [COLS*DATA_W-1:0]  w_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [COLS*ACC_W-1:0]   y_out,
   output logic [RW-1:0]           y_row,
   output logic                    out_last,
   output logic                    busy
);

   localparam int FW = $clog2(ROWS + COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH,
      S_DRAIN
   } state_e;

   state_e          state_q;
   logic [KW-1:0]   k_len_q;
   logic [KW-1:0]   cnt_q;
   logic [FW-1:0]   fl_q;
   logic [RW-1:0]   y_row_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            out_last_q;
   logic            busy_q;

   logic            k_ok;
   logic            accept;
   logic            advance;
   logic            clr;
   logic [RW-1:0]   y_nxt;

   logic [DATA_W-1:0] x_inj [ROWS];
   logic [DATA_W-1:0] w_inj [COLS];
   logic [DATA_W-1:0] x_row [ROWS];
   logic [DATA_W-1:0] w_col [COLS];
   logic [DATA_W-1:0] xe    [ROWS][COLS];
   logic [DATA_W-1:0] we    [ROWS][COLS];

   logic [DATA_W-1:0] xsk_q [ROWS][ROWS];
   logic [DATA_W-1:0] wsk_q [COLS][COLS];
   logic [DATA_W-1:0] xp_q  [ROWS][COLS];
   logic [DATA_W-1:0] wp_q  [ROWS][COLS];
   logic [ACC_W-1:0]  acc_q [ROWS][COLS];

   function automatic logic [ACC_W-1:0] mac(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic signed [2*DATA_W-1:0] p;
      p = $signed(a) * $signed(b);
      return ACC_W'(p);
   endfunction

   assign k_ok    = (k_len != '0) && (k_len <= KW'(K_MAX));
   assign accept  = in_valid & in_ready_q;
   assign advance = (state_q == S_FEED) || (state_q == S_FLUSH);
   assign clr     = (state_q == S_IDLE) & start & k_ok & ~acc_keep;
   assign y_nxt   = y_row_q + RW'(1);

   // Row i sees its x lane i cycles late, column j its w lane j late.
   for (genvar i = 0; i < ROWS; i++) begin : g_xin
      assign x_inj[i] = accept ? x_in[i*DATA_W +: DATA_W] : '0;
      if (i == 0) begin : g_d0
         assign x_row[i] = x_inj[i];
      end else begin : g_dn
         assign x_row[i] = xsk_q[i][i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_win
      assign w_inj[j] = accept ? w_in[j*DATA_W +: DATA_W] : '0;
      if (j == 0) begin : g_d0
         assign w_col[j] = w_inj[j];
      end else begin : g_dn
         assign w_col[j] = wsk_q[j][j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_r
      for (genvar j = 0; j < COLS; j++) begin : g_c
         if (j == 0) begin : g_xl
            assign xe[i][j] = x_row[i];
         end else begin : g_xp
            assign xe[i][j] = xp_q[i][j-1];
         end
         if (i == 0) begin : g_wt
            assign we[i][j] = w_col[j];
         end else begin : g_wp
            assign we[i][j] = wp_q[i-1][j];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         k_len_q     <= '0;
         cnt_q       <= '0;
         fl_q        <= '0;
         y_row_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && k_ok) begin
                  state_q    <= S_FEED;
                  k_len_q    <= k_len;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_FEED: begin
               if (accept) begin
                  cnt_q <= cnt_q + KW'(1);
                  if (cnt_q == k_len_q - KW'(1)) begin
                     state_q    <= S_FLUSH;
                     in_ready_q <= 1'b0;
                     fl_q       <= '0;
                  end
               end
            end
            S_FLUSH: begin
               fl_q <= fl_q + FW'(1);
               if (fl_q == FW'(ROWS + COLS - 2)) begin
                  state_q     <= S_DRAIN;
                  out_valid_q <= 1'b1;
                  y_row_q     <= '0;
                  out_last_q  <= (ROWS == 1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (y_row_q == RW'(ROWS - 1)) begin
                     state_q     <= S_IDLE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     y_row_q     <= '0;
                  end else begin
                     y_row_q    <= y_nxt;
                     out_last_q <= (y_nxt == RW'(ROWS - 1));
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Accumulators hold outside FEED/FLUSH so a later pass can keep them.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int d = 0; d < ROWS; d++) xsk_q[i][d] <= '0;
            for (int j = 0; j < COLS; j++) begin
               xp_q[i][j]  <= '0;
               wp_q[i][j]  <= '0;
               acc_q[i][j] <= '0;
            end
         end
         for (int j = 0; j < COLS; j++) begin
            for (int d = 0; d < COLS; d++) wsk_q[j][d] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
         end
      end else if (advance) begin
         for (int i = 0; i < ROWS; i++) begin
            xsk_q[i][0] <= x_inj[i];
            for (int d = 1; d < ROWS; d++) xsk_q[i][d] <= xsk_q[i][d-1];
         end
         for (int j = 0; j < COLS; j++) begin
            wsk_q[j][0] <= w_inj[j];
            for (int d = 1; d < COLS; d++) wsk_q[j][d] <= wsk_q[j][d-1];
         end
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
               xp_q[i][j]  <= xe[i][j];
               wp_q[i][j]  <= we[i][j];
               acc_q[i][j] <= acc_q[i][j] + mac(xe[i][j], we[i][j]);
            end
         end
      end
   end

   always_comb begin
      y_out = '0;
      for (int j = 0; j < COLS; j++) begin
         y_out[j*ACC_W +: ACC_W] = acc_q[y_row_q][j];
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign y_row     = y_row_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os: a 32-bit and a 16-bit accumulator
// instance share stimulus; expected rows are queued and checked on drain.
module tb_systolic_array_os;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int DW = 8;
   localparam int KM = 256;
   localparam int KW = $clog2(KM + 1);

   logic clk = 1'b0;
   logic n_rst;
   logic start;
   logic [KW-1:0] k_len;
   logic acc_keep;
   logic in_valid;
   logic [R*DW-1:0] x_in;
   logic [C*DW-1:0] w_in;
   logic out_ready;

   logic in_ready, out_valid, out_last, busy;
   logic [C*32-1:0] y_out;
   logic [1:0] y_row;

   logic in_ready_h, out_valid_h, out_last_h, busy_h;
   logic [C*16-1:0] y_out_h;
   logic [1:0] y_row_h;

   always #5 clk = ~clk;

   systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32),
                       .K_MAX(KM)) u_dut (
      .clk(clk), .n_rst(n_rst), .start(start), .k_len(k_len),
      .acc_keep(acc_keep), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .w_in(w_in), .out_valid(out_valid),
      .out_ready(out_ready), .y_out(y_out), .y_row(y_row),
      .out_last(out_last), .busy(busy)
   );

   systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16),
                       .K_MAX(KM)) u_h (
      .clk(clk), .n_rst(n_rst), .start(start), .k_len(k_len),
      .acc_keep(acc_keep), .in_valid(in_valid), .in_ready(in_ready_h),
      .x_in(x_in), .w_in(w_in), .out_valid(out_valid_h),
      .out_ready(out_ready), .y_out(y_out_h), .y_row(y_row_h),
      .out_last(out_last_h), .busy(busy_h)
   );

   typedef struct {
      int           row;
      logic [127:0] y;
      logic [63:0]  yh;
      bit           last;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;
   logic signed [7:0] A [4][4];
   logic signed [7:0] B [4][4];
   logic [31:0] m [4][4];

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) m[i][j] = '0;
   endtask

   task automatic feed(input int kb, input int kl, input bit keep,
                       input bit gaps, input bit poke);
      int sent, cyc;
      @(negedge clk);
      start = 1'b1; k_len = kl[KW-1:0]; acc_keep = keep;
      if (!keep) clear_model();
      @(negedge clk);
      start = 1'b0;
      sent = 0; cyc = 0;
      while (sent < kl && cyc < 64) begin
         in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
         for (int i = 0; i < R; i++) x_in[i*DW +: DW] = A[i][kb+sent];
         for (int j = 0; j < C; j++) w_in[j*DW +: DW] = B[kb+sent][j];
         if (poke && cyc == 1) begin
            start = 1'b1; acc_keep = 1'b0; k_len = 1;
         end else begin
            start = 1'b0;
         end
         chk("in_ready_feed", in_ready, 1);
         if (in_valid && in_ready) begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  m[i][j] = m[i][j] +
                     32'(int'(A[i][kb+sent]) * int'(B[kb+sent][j]));
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; start = 1'b0; x_in = '0; w_in = '0;
      chk("beats_accepted", sent, kl);
      chk("in_ready_flush", in_ready, 0);
   endtask

   task automatic push_exp();
      exp_t e;
      for (int i = 0; i < R; i++) begin
         e.row = i;
         e.y = '0; e.yh = '0;
         for (int j = 0; j < C; j++) begin
            e.y[j*32 +: 32]  = m[i][j];
            e.yh[j*16 +: 16] = m[i][j][15:0];
         end
         e.last = (i == R - 1);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input int stall_row);
      int n;
      exp_t e;
      logic [127:0] cap;
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, R + C);
      for (int r = 0; r < R; r++) begin
         if (r == stall_row) begin
            out_ready = 1'b0;
            cap = y_out;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("stall_y_row", y_row, r);
               chk("stall_y_out", y_out, cap);
               chk("stall_valid", out_valid, 1);
               chk("stall_busy", busy, 1);
            end
            out_ready = 1'b1;
         end
         e = sb.pop_front();
         chk("y_row", y_row, e.row);
         chk("y_out", y_out, e.y);
         chk("y_out_16", y_out_h, e.yh);
         chk("out_last", out_last, e.last);
         chk("drain_busy", busy, 1);
         @(negedge clk);
      end
      chk("post_valid", out_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_y_row", y_row, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_y_row"}, y_row, 0);
      chk({tag, "_y_out"}, y_out, 0);
      chk({tag, "_y_out_16"}, y_out_h, 0);
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; k_len = '0; acc_keep = 1'b0;
      in_valid = 1'b0; x_in = '0; w_in = '0; out_ready = 1'b1;
      clear_model();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      n_rst = 1'b1;
      @(negedge clk);
      chk_zero("idle");

      // identity A, B = 1..16
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            A[i][k] = (i == k) ? 8'sd1 : 8'sd0;
            B[i][k] = 8'(i * 4 + k + 1);
         end
      feed(0, 4, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);

      // bubbles, a start poked mid-FEED, and drain back-pressure
      feed(0, 4, 1'b0, 1'b1, 1'b1);
      push_exp();
      drain(1);

      // signed wrap
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            A[i][k] = -8'sd128;
            B[i][k] = -8'sd128;
         end
      feed(0, 4, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);
      feed(0, 3, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);

      // tiled K with random signed operands
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            A[i][k] = 8'($urandom_range(0, 255));
            B[i][k] = 8'($urandom_range(0, 255));
         end
      feed(0, 4, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);
      feed(0, 2, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);
      feed(2, 2, 1'b1, 1'b0, 1'b0);
      push_exp();
      drain(-1);
      feed(2, 2, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);

      // out-of-range k_len starts are ignored
      @(negedge clk);
      start = 1'b1; k_len = 0;
      @(negedge clk);
      start = 1'b0;
      chk("k0_busy", busy, 0);
      chk("k0_in_ready", in_ready, 0);
      start = 1'b1; k_len = 300;
      @(negedge clk);
      start = 1'b0;
      chk("kbig_busy", busy, 0);
      @(negedge clk);
      chk("kbig_in_ready", in_ready, 0);

      // reset pulsed mid-FLUSH
      feed(0, 4, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("flush_busy", busy, 1);
      n_rst = 1'b0;
      #1;
      chk_zero("mid_flush_rst");
      @(negedge clk);
      n_rst = 1'b1;
      clear_model();
      feed(0, 4, 1'b0, 1'b0, 1'b0);
      push_exp();
      drain(-1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Output-stationary ROWS x COLS MAC array, the parametrised successor to the square fixed-size array.
- Owns its input skew, K-length sequencing, pipeline flush, accumulator carry-over for tiled K, and a valid/ready row-by-row result drain.
- Sits between the operand buffers (A columns, B rows) and the result writeback.

Parameters:
- ROWS, 4, array rows; number of A lanes and result rows.
- COLS, 4, array columns; number of B lanes and result columns.
- DATA_W, 8, operand width, signed two's complement.
- ACC_W, 32, accumulator width.
- K_MAX, 256, maximum reduction length per pass.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  begin pass; sampled only in IDLE.
- k_len  in  $clog2(K_MAX+1)  beats this pass, valid 1..K_MAX.
- acc_keep  in  1  sampled with start; 1 keeps accumulators, 0 clears them.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  array accepts beat.
- x_in  in  ROWS*DATA_W  column k of A; lane i drives row i.
- w_in  in  COLS*DATA_W  row k of B; lane j drives column j.
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts row.
- y_out  out  COLS*ACC_W  accumulators of row y_row.
- y_row  out  $clog2(ROWS) (min 1)  index of presented row.
- out_last  out  1  presented row is ROWS-1.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, immediate, any state): FSM to IDLE. Accumulators, skew registers, counters and all outputs go to 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE: in_ready=0, out_valid=0, busy=0.
  - start=1 with k_len in 1..K_MAX: go to FEED next cycle. acc_keep=0 zeroes all accumulators at the same edge.
  - k_len=0 or k_len>K_MAX: start ignored.
- Starts outside IDLE are ignored.
- FEED: in_ready=1. A beat is accepted when in_valid&in_ready.
  - After the k_len-th accepted beat, go to FLUSH.
- Array pipeline: the array advances every cycle in FEED and FLUSH.
  - Each cycle, the accepted beat is injected, or zeros if no beat was accepted (bubble).
  - Row-i x lane is delayed i cycles; column-j w lane is delayed j cycles.
  - Each PE registers its x rightward and w downward.
  - Each PE does acc += x*w: signed DATA_W x DATA_W product, sign-extended to ACC_W, wraps modulo 2^ACC_W.
  - Bubbles contribute 0, so results are independent of in_valid gaps.
- FLUSH: in_ready=0, zeros injected for exactly ROWS+COLS-1 cycles, then DRAIN.
  - After FLUSH every PE has consumed all k_len products.
- DRAIN: y_row starts at 0. out_valid=1. y_out = row y_row, column j at bits [j*ACC_W +: ACC_W]. out_last = (y_row==ROWS-1).
  - out_valid&out_ready increments y_row. Without it, y_out and y_row hold stable.
  - Handshake on row ROWS-1: go to IDLE next cycle with out_valid=0, y_row=0.
  - Accumulators are retained after DRAIN, for acc_keep.
- Latency: start at cycle t, in_ready=1 at t+1.
  - Last beat at cycle b, out_valid=1 at b+ROWS+COLS.
  - With out_ready=1, the drain lasts ROWS cycles.
- Array state is not frozen during FEED; back-pressure is expressed only by in_valid gaps.

Test Plan:
- Identity:
  - Stimulus: ROWS=COLS=4, DATA_W=8, ACC_W=32, A=I, B=[[1..4],[5..8],[9..12],[13..16]], k_len=4, acc_keep=0, in_valid=1, out_ready=1.
  - Required: rows 0..3 equal B rows. out_valid exactly 4 cycles after last beat+4. out_last only on row 3.
- Bubbles:
  - Stimulus: same operands, in_valid toggled 1,0,1,0….
  - Required: identical y_out. in_ready high until the 4th accepted beat.
- Signed wrap:
  - Stimulus: ACC_W=16, all operands -128, k_len=4.
  - Required: every element 4*16384 mod 65536 = 0.
  - Stimulus: k_len=3 with the same operands.
  - Required: 49152 as 16-bit (-16384).
- Tiled K:
  - Stimulus: pass 1 with k_len=2 (beats 0,1), then start with acc_keep=1 and k_len=2 (beats 2,3).
  - Required: drained result equals the single k_len=4 pass. Pass 2 with acc_keep=0 gives only the beats 2..3 sum.
- Drain back-pressure:
  - Stimulus: out_ready=0 for 3 cycles while y_row=1.
  - Required: y_row=1 and y_out stable throughout. busy=1 until the cycle after the row-3 handshake.
- Boundaries:
  - Stimulus: start with k_len=0.
    - Required: stays IDLE, busy=0.
  - Stimulus: start during FEED.
    - Required: ignored.
  - Stimulus: n_rst pulsed mid-FLUSH.
    - Required: outputs 0 immediately. Next valid pass produces correct results with acc_keep=0.
